// File: rtl/decode_issue.sv
// fost decode/issue stage: decode, register read with write-back
// forwarding, pending-write scoreboard, local JMP and HALT handling.
module decode_issue #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int NUM_WB = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_inst,
  input  logic [PC_W-1:0]          in_pc,
  input  logic                     flush,
  input  logic [NUM_WB-1:0]        wb_en,
  input  logic [4*NUM_WB-1:0]      wb_addr,
  input  logic [DATA_W*NUM_WB-1:0] wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_alu,
  output logic [1:0]               out_cmp,
  output logic                     out_mem_rd,
  output logic                     out_mem_wr,
  output logic                     out_reg_wr,
  output logic [DATA_W-1:0]        out_val1,
  output logic [DATA_W-1:0]        out_val2,
  output logic [PC_W-1:0]          out_val3,
  output logic [3:0]               out_dst,
  output logic                     redirect_valid,
  output logic [PC_W-1:0]          redirect_pc,
  output logic                     halted
);

  typedef struct packed {
    logic [1:0]        alu;
    logic [1:0]        cmp;
    logic              mem_rd;
    logic              mem_wr;
    logic              reg_wr;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [PC_W-1:0]   val3;
    logic [3:0]        dst;
  } dec_t;

  logic [DATA_W-1:0] rf [16];
  logic [1:0]        cnt [16];
  logic              discard;
  dec_t              dec, out_q;

  logic [3:0] op, rd, rs, rt;
  assign op = in_inst[15:12];
  assign rd = in_inst[11:8];
  assign rs = in_inst[7:4];
  assign rt = in_inst[3:0];

  logic c_rr, c_ri, c_inc, c_ldi, c_ld;
  logic c_st, c_br, c_jmp, c_halt;
  assign c_rr   = (op >= 4'h1) && (op <= 4'h4);
  assign c_ri   = (op == 4'h5) || (op == 4'h6);
  assign c_inc  = (op == 4'h7);
  assign c_ldi  = (op == 4'h8);
  assign c_ld   = (op == 4'h9);
  assign c_st   = (op == 4'hA);
  assign c_br   = (op == 4'hC) || (op == 4'hD);
  assign c_jmp  = (op == 4'hE);
  assign c_halt = (op == 4'hF);

  logic [DATA_W-1:0] imm_s, imm_z, rt_z;
  logic [PC_W-1:0]   rt_pc, br_tgt, jmp_tgt;
  assign imm_s = {{(DATA_W-8){in_inst[7]}}, in_inst[7:0]};
  assign imm_z = DATA_W'(in_inst[7:0]);
  assign rt_z  = DATA_W'(rt);
  assign rt_pc = {{(PC_W-4){rt[3]}}, rt};
  assign br_tgt  = in_pc + rt_pc;
  assign jmp_tgt = in_pc + {{(PC_W-9){in_inst[8]}}, in_inst[8:0]};

  // Lowest-index write-back port wins, hence the descending scan.
  logic [DATA_W-1:0] v_rd, v_rs;
  logic              h_rd, h_rs;
  logic [15:0]       wb_hit;
  always_comb begin
    v_rd   = rf[rd];
    v_rs   = rf[rs];
    h_rd   = 1'b0;
    h_rs   = 1'b0;
    wb_hit = '0;
    for (int k = NUM_WB-1; k >= 0; k--) begin
      if (wb_en[k]) begin
        wb_hit[wb_addr[4*k +: 4]] = 1'b1;
        if (wb_addr[4*k +: 4] == rd) begin
          v_rd = wb_data[DATA_W*k +: DATA_W];
          h_rd = 1'b1;
        end
        if (wb_addr[4*k +: 4] == rs) begin
          v_rs = wb_data[DATA_W*k +: DATA_W];
          h_rs = 1'b1;
        end
      end
    end
  end

  logic use_rd, use_rs, issue;
  always_comb begin
    dec    = '0;
    use_rd = 1'b0;
    use_rs = 1'b0;
    unique case (1'b1)
      c_rr: begin
        dec.alu  = 2'(op[1:0] - 2'd1);
        dec.val1 = v_rd;
        dec.val2 = v_rs;
        use_rd   = 1'b1;
        use_rs   = 1'b1;
      end
      c_ri: begin
        dec.alu  = {1'b0, op[1]};
        dec.val1 = v_rd;
        dec.val2 = imm_s;
        use_rd   = 1'b1;
      end
      c_inc: begin
        dec.val1 = v_rd;
        dec.val2 = DATA_W'(1);
        use_rd   = 1'b1;
      end
      c_ldi: begin
        dec.val1   = imm_z;
        dec.mem_rd = 1'b1;
      end
      c_ld: begin
        dec.val1   = v_rs;
        dec.val2   = rt_z;
        dec.mem_rd = 1'b1;
        use_rs     = 1'b1;
      end
      c_st: begin
        dec.val1   = v_rs;
        dec.val2   = v_rd;
        dec.val3   = PC_W'(rt);
        dec.mem_wr = 1'b1;
        use_rd     = 1'b1;
        use_rs     = 1'b1;
      end
      c_br: begin
        dec.cmp  = op[0] ? 2'd2 : 2'd1;
        dec.val1 = v_rd;
        dec.val2 = v_rs;
        dec.val3 = br_tgt;
        use_rd   = 1'b1;
        use_rs   = 1'b1;
      end
      default: ;
    endcase
    dec.reg_wr = c_rr | c_ri | c_inc | c_ldi | c_ld;
    dec.dst    = dec.reg_wr ? rd : 4'd0;
  end
  assign issue = c_rr | c_ri | c_inc | c_ldi |
                 c_ld | c_st | c_br;

  logic busy_rd, busy_rs, raw_out, full, stall;
  assign busy_rd = use_rd && cnt[rd] != 2'd0 && !h_rd;
  assign busy_rs = use_rs && cnt[rs] != 2'd0 && !h_rs;
  assign raw_out = out_valid && out_q.reg_wr &&
                   ((use_rd && out_q.dst == rd) ||
                    (use_rs && out_q.dst == rs));
  assign full    = dec.reg_wr && cnt[rd] == 2'd3;
  assign stall   = busy_rd | busy_rs | raw_out | full;

  logic adv, accept, take, hs;
  assign adv      = !out_valid || out_ready;
  assign in_ready = flush || discard ||
                    (!halted && !stall && adv);
  assign accept   = in_valid && in_ready;
  assign take     = accept && !flush && !discard;
  assign hs       = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 16; r++) begin
        rf[r]  <= '0;
        cnt[r] <= '0;
      end
      out_q          <= '0;
      out_valid      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      halted         <= 1'b0;
      discard        <= 1'b0;
    end else begin
      for (int k = NUM_WB-1; k >= 0; k--)
        if (wb_en[k])
          rf[wb_addr[4*k +: 4]] <= wb_data[DATA_W*k +: DATA_W];
      for (int r = 0; r < 16; r++) begin
        if (hs && out_q.reg_wr && out_q.dst == 4'(r)) begin
          if (!wb_hit[r]) cnt[r] <= cnt[r] + 2'd1;
        end else if (wb_hit[r] && cnt[r] != 2'd0) begin
          cnt[r] <= cnt[r] - 2'd1;
        end
      end
      if (flush) begin
        out_valid      <= 1'b0;
        redirect_valid <= 1'b0;
        discard        <= 1'b0;
        halted         <= 1'b0;
      end else begin
        redirect_valid <= take && c_jmp;
        if (take && c_jmp) redirect_pc <= jmp_tgt;
        if (take && c_halt) halted <= 1'b1;
        if (discard && accept) discard <= 1'b0;
        else if (take && c_jmp) discard <= 1'b1;
        if (adv) begin
          out_valid <= take && issue;
          if (take && issue) out_q <= dec;
        end
      end
    end
  end

  assign out_alu    = out_q.alu;
  assign out_cmp    = out_q.cmp;
  assign out_mem_rd = out_q.mem_rd;
  assign out_mem_wr = out_q.mem_wr;
  assign out_reg_wr = out_q.reg_wr;
  assign out_val1   = out_q.val1;
  assign out_val2   = out_q.val2;
  assign out_val3   = out_q.val3;
  assign out_dst    = out_q.dst;

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: operand forwarding, scoreboard
// interlock, JMP redirect/discard, flush and HALT.
module tb_decode_issue;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_inst;
  logic [15:0] in_pc;
  logic        flush;
  logic [1:0]  wb_en;
  logic [7:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_alu;
  logic [1:0]  out_cmp;
  logic        out_mem_rd;
  logic        out_mem_wr;
  logic        out_reg_wr;
  logic [15:0] out_val1;
  logic [15:0] out_val2;
  logic [15:0] out_val3;
  logic [3:0]  out_dst;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halted;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_issue #(.DATA_W(16), .PC_W(16), .NUM_WB(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu(out_alu), .out_cmp(out_cmp),
    .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
    .out_reg_wr(out_reg_wr),
    .out_val1(out_val1), .out_val2(out_val2),
    .out_val3(out_val3), .out_dst(out_dst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halted(halted)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb1(input logic [3:0] a, input logic [15:0] d);
    wb_en   = 2'b01;
    wb_addr = {4'd0, a};
    wb_data = {16'd0, d};
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0;
    flush = 1'b0; wb_en = '0; wb_addr = '0; wb_data = '0;
    out_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_redirect", 32'(redirect_valid), 0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 1);

    // R1=5 via port0, R2=7 via port1
    wb_en = 2'b11; wb_addr = {4'd2, 4'd1};
    wb_data = {16'd7, 16'd5};
    tick();
    wb_en = '0;

    // ADD r1,r2
    in_inst = 16'h1120; in_valid = 1'b1;
    #1;
    check("add_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    wb1(4'd1, 16'd5);
    check("add_valid", 32'(out_valid), 1);
    check("add_alu", 32'(out_alu), 0);
    check("add_val1", 32'(out_val1), 5);
    check("add_val2", 32'(out_val2), 7);
    check("add_dst", 32'(out_dst), 1);
    check("add_reg_wr", 32'(out_reg_wr), 1);
    tick();
    wb_en = '0;
    check("add_drain", 32'(out_valid), 0);

    // LD r3 then dependent ADD r4,r3
    in_inst = 16'h9300; in_valid = 1'b1;
    tick();
    check("ld_mem_rd", 32'(out_mem_rd), 1);
    check("ld_dst", 32'(out_dst), 3);
    in_inst = 16'h1430;
    #1;
    check("ld_raw_out", 32'(in_ready), 0);
    tick();
    check("ld_pending0", 32'(in_ready), 0);
    tick();
    check("ld_pending1", 32'(in_ready), 0);
    check("ld_no_issue", 32'(out_valid), 0);
    wb1(4'd3, 16'h2A);
    #1;
    check("ld_wb_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    wb1(4'd4, 16'd0);
    check("fwd_valid", 32'(out_valid), 1);
    check("fwd_val2", 32'(out_val2), 16'h2A);
    check("fwd_val1", 32'(out_val1), 0);
    check("fwd_dst", 32'(out_dst), 4);
    tick();
    wb_en = '0;

    // SUBI r5,-1 with both ports writing r5
    in_inst = 16'h65FF; in_valid = 1'b1;
    wb_en = 2'b11; wb_addr = {4'd5, 4'd5};
    wb_data = {16'h22, 16'h11};
    tick();
    wb_en = '0;
    out_ready = 1'b0;
    in_inst = 16'h1660;
    check("subi_val1", 32'(out_val1), 16'h11);
    check("subi_val2", 32'(out_val2), 16'hFFFF);
    check("subi_alu", 32'(out_alu), 1);
    #1;
    check("hold_in_ready", 32'(in_ready), 0);
    tick();
    check("hold_valid", 32'(out_valid), 1);
    check("hold_val1", 32'(out_val1), 16'h11);
    flush = 1'b1;
    #1;
    check("flush_in_ready", 32'(in_ready), 1);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("flush_valid", 32'(out_valid), 0);

    // ST r5 (rd=5,rs=5,rt=2): no pending count left on r5
    in_inst = 16'hA552; in_valid = 1'b1;
    #1;
    check("st_in_ready", 32'(in_ready), 1);
    tick();
    check("st_valid", 32'(out_valid), 1);
    check("st_val1", 32'(out_val1), 16'h11);
    check("st_val2", 32'(out_val2), 16'h11);
    check("st_val3", 32'(out_val3), 2);
    check("st_mem_wr", 32'(out_mem_wr), 1);
    check("st_reg_wr", 32'(out_reg_wr), 0);

    // LDI r7,0x9C
    in_inst = 16'h879C;
    tick();
    check("ldi_val1", 32'(out_val1), 16'h9C);
    check("ldi_val2", 32'(out_val2), 0);
    check("ldi_dst", 32'(out_dst), 7);

    // BEQ r1,r2,-2 at pc 0x20
    in_inst = 16'hC12E; in_pc = 16'h20;
    tick();
    check("beq_cmp", 32'(out_cmp), 1);
    check("beq_val3", 32'(out_val3), 16'h1E);
    check("beq_val1", 32'(out_val1), 5);
    check("beq_reg_wr", 32'(out_reg_wr), 0);

    // JMP at pc 0x10, i9=0x1F8 (-8)
    in_inst = 16'hE1F8; in_pc = 16'h10;
    tick();
    check("jmp_redirect", 32'(redirect_valid), 1);
    check("jmp_pc", 32'(redirect_pc), 16'h08);
    check("jmp_no_out", 32'(out_valid), 0);
    in_inst = 16'h1120; in_pc = 16'h08;
    #1;
    check("disc_in_ready", 32'(in_ready), 1);
    tick();
    check("disc_redirect", 32'(redirect_valid), 0);
    check("disc_dropped", 32'(out_valid), 0);
    tick();
    in_valid = 1'b0;
    wb1(4'd1, 16'd5);
    check("post_disc_valid", 32'(out_valid), 1);
    check("post_disc_val1", 32'(out_val1), 5);
    tick();
    wb_en = '0;

    // HALT, then ADD stays blocked
    in_inst = 16'hF000; in_valid = 1'b1;
    tick();
    check("halt_set", 32'(halted), 1);
    in_inst = 16'h1120;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("halt_in_ready", 32'(in_ready), 0);
      tick();
    end
    check("halt_no_out", 32'(out_valid), 0);
    check("halt_sticky", 32'(halted), 1);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    check("rst2_halted", 32'(halted), 0);
    check("rst2_valid", 32'(out_valid), 0);
    check("rst2_redir_pc", 32'(redirect_pc), 0);
    check("rst2_val1", 32'(out_val1), 0);
    check("rst2_dst", 32'(out_dst), 0);
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_issue.md
# decode_issue

Parametrised decode/issue stage for the 16-bit fost pipeline, between fetch and execute. It decodes one instruction per cycle and reads a 16-entry register file with N-port write-back forwarding. A per-register pending-write scoreboard interlocks against in-flight results. It also resolves JMP locally, squashes on branch flush, and latches HALT, using valid/ready handshakes on both sides.

## Interface
- DATA_W, 16: register/operand width; must be ≥ 9.
- PC_W, 16: program-counter width.
- NUM_WB, 2: write-back ports; lower index has priority.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid / in_ready  in/out  1  fetch handshake.
- in_inst  in  16  fields: op[15:12], rd[11:8], rs[7:4], rt[3:0], imm8[7:0], i9[8:0].
- in_pc  in  PC_W  address of in_inst.
- flush  in  1  branch taken in execute; squash.
- wb_en  in  NUM_WB  write-back enables.
- wb_addr  in  4*NUM_WB  port k at [4k+3:4k].
- wb_data  in  DATA_W*NUM_WB  port k at [DATA_W*k +: DATA_W].
- out_valid / out_ready  out/in  1  execute handshake.
- out_alu  out  2  0 add, 1 sub, 2 and, 3 or.
- out_cmp  out  2  0 none, 1 eq, 2 gt.
- out_mem_rd, out_mem_wr, out_reg_wr  out  1 each.
- out_val1, out_val2  out  DATA_W  operands.
- out_val3  out  PC_W  branch target or store offset.
- out_dst  out  4  destination register.
- redirect_valid  out  1  one-cycle JMP redirect.
- redirect_pc  out  PC_W  JMP target.
- halted  out  1  HALT decoded; sticky.

## Operation
- Opcode map:
  - 0 NOP; B is reserved and decodes as NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR: val1=R[rd], val2=R[rs].
  - 5 ADDI / 6 SUBI: val1=R[rd], val2=sext(imm8).
  - 7 INC: val1=R[rd], val2=1.
  - 8 LDI: val1=zext(imm8), val2=0, mem_rd.
  - 9 LD: val1=R[rs], val2=zext(rt), mem_rd.
  - A ST: val1=R[rs], val2=R[rd], val3=zext(rt), mem_wr.
  - C BEQ / D BGT: val1=R[rd], val2=R[rs], val3=in_pc+sext(rt), out_alu=0 (add), out_cmp=eq/gt.
  - E JMP: target = in_pc+sext(i9).
  - F HALT.
- out_reg_wr=1 and out_dst=rd for ops 1–9.
- NOP, JMP and HALT never produce out_valid.
- Operand read: the lowest-index wb port with wb_en[k] and a matching address supplies the value. Otherwise the value comes from the register file.
- Register file writes every enabled wb port every cycle, independent of stall, flush or halt. If two ports hit the same address, the lower index wins.
- Scoreboard: a 2-bit pending counter per register.
  - Increments on an out handshake (out_valid & out_ready & !flush) with out_reg_wr.
  - Decrements per cycle if any wb port writes that register.
  - Simultaneous increment and decrement leaves it unchanged.
- stall is asserted when either:
  - a source register has count≠0 and no wb port supplies it this cycle; or
  - out_valid & out_reg_wr & out_dst equals a source; or
  - a writer's rd has count==3.
- in_ready = !halted & !stall & (!out_valid | out_ready). In the flush or discard cycle, in_ready is forced to 1.
- Accepted JMP: redirect_valid=1 and redirect_pc=target next cycle. The instruction accepted in the following cycle is dropped (discard).
- Accepted HALT: halted=1, which holds in_ready=0 until rst or flush.
- flush:
  - Next edge: out_valid=0, redirect_valid=0, discard=0, halted=0.
  - The input presented that cycle is dropped.
  - The scoreboard is not incremented.

## Timing
- Reset: all outputs 0, register file 0, counters 0, discard 0.
- Latency: in handshake at edge n gives out_valid after edge n (1 cycle).
- While out_valid & !out_ready, all out_* remain stable.
- Back-to-back issue at 1/cycle when no stall occurs.
- Priority: rst > flush > discard > normal decode.

## Test plan
- ADD r1,r2 with R1=5, R2=7 -> one cycle later out_alu=0, val1=5, val2=7, dst=1, reg_wr=1.
- LD r3 issued, then ADD r4,r3 presented -> in_ready=0 until wb_en[0] with addr 3 and data 0x2A; that cycle ADD is accepted with val2=0x2A.
- wb port0 and port1 both write r5 (0x11 / 0x22) while SUBI r5,-1 is decoded -> val1=0x11, val2=all-ones; R5 becomes 0x11.
- JMP with pc=0x10, i9=0x1F8 -> redirect_valid for one cycle with redirect_pc=0x08; next accepted instruction dropped, no out_valid.
- out_valid held with out_ready=0 while flush=1 -> next cycle out_valid=0, all scoreboard counters unchanged.
- HALT accepted -> halted=1, in_ready=0 for 10 cycles; rst asserted -> all outputs 0.
